// File: rtl/vend_pkg.sv
// Shared types and defaults for the parametrised vending controller.
// The optional stock counter is enabled by defining VEND_STOCK_EN.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    REFUND  = 2'd3
  } state_t;

  localparam int COIN_A = 0;
  localparam int COIN_B = 1;
  localparam int COIN_C = 2;

  localparam int DEF_CW         = 4;
  localparam int DEF_PRICE      = 5;
  localparam int DEF_VAL_A      = 1;
  localparam int DEF_VAL_B      = 2;
  localparam int DEF_VAL_C      = 5;
  localparam int DEF_STOCK_W    = 4;
  localparam int DEF_STOCK_INIT = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vend_coin_sel.sv
// Priority coin selector (a > b > c): reports whether a coin is offered,
// its value, and whether lower-priority coins were dropped.
module vend_coin_sel
  import vend_pkg::*;
#(
  parameter int CW    = DEF_CW,
  parameter int VAL_A = DEF_VAL_A,
  parameter int VAL_B = DEF_VAL_B,
  parameter int VAL_C = DEF_VAL_C
) (
  input  logic [2:0]    coins,
  output logic          valid,
  output logic [CW-1:0] value,
  output logic          multi
);

  localparam logic [CW-1:0] VA = CW'(VAL_A);
  localparam logic [CW-1:0] VB = CW'(VAL_B);
  localparam logic [CW-1:0] VC = CW'(VAL_C);

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    valid = |coins;
    value = '0;
    multi = (coins[COIN_A] & (coins[COIN_B] | coins[COIN_C])) |
            (coins[COIN_B] & coins[COIN_C]);
    if (coins[COIN_A])      value = VA;
    else if (coins[COIN_B]) value = VB;
    else if (coins[COIN_C]) value = VC;
  end

endmodule

// File: rtl/vend_fsm_param.sv
// Vending controller: coin accumulation, one-cycle vend, change handshake.
// Define VEND_STOCK_EN to add a stock counter with restock/sold_out ports.
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int CW    = DEF_CW,
  parameter int PRICE = DEF_PRICE,
  parameter int VAL_A = DEF_VAL_A,
  parameter int VAL_B = DEF_VAL_B,
  parameter int VAL_C = DEF_VAL_C
`ifdef VEND_STOCK_EN
  ,
  parameter int STOCK_W    = DEF_STOCK_W,
  parameter int STOCK_INIT = DEF_STOCK_INIT
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          coin_a,
  input  logic          coin_b,
  input  logic          coin_c,
  input  logic          cancel,
  input  logic          change_ack,
  output logic          dispense,
  output logic          change_valid,
  output logic [CW-1:0] change,
  output logic [CW-1:0] credit,
  output logic          busy,
  output logic          coin_err
`ifdef VEND_STOCK_EN
  ,
  input  logic          restock,
  output logic          sold_out
`endif
);

  if (PRICE < 1 || PRICE - 1 + max3(VAL_A, VAL_B, VAL_C) > (2 ** CW) - 1) begin : g_bad_params
    $error("vend_fsm_param: PRICE/coin values do not fit in CW bits");
  end

  localparam logic [CW:0] PRICE_W = (CW + 1)'(PRICE);

  state_t        state, state_n;
  logic [CW-1:0] credit_n;
  logic          coin_err_n;
  logic          sel_valid, sel_multi;
  logic [CW-1:0] sel_value;
  logic [CW:0]   sum;
  logic          stock_ok;

  vend_coin_sel #(
    .CW(CW), .VAL_A(VAL_A), .VAL_B(VAL_B), .VAL_C(VAL_C)
  ) u_coin_sel (
    .coins ({coin_c, coin_b, coin_a}),
    .valid (sel_valid),
    .value (sel_value),
    .multi (sel_multi)
  );

`ifdef VEND_STOCK_EN
  logic [STOCK_W-1:0] stock;

  // Restock takes precedence over the decrement on VEND entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               stock <= STOCK_W'(STOCK_INIT);
    else if (restock)                        stock <= STOCK_W'(STOCK_INIT);
    else if (state_n == VEND && state != VEND) stock <= stock - 1'b1;
  end

  assign stock_ok = (stock != '0);
  assign sold_out = ~stock_ok;
`else
  assign stock_ok = 1'b1;
`endif

  // Sum is one bit wider than credit so the PRICE comparison cannot wrap.
  assign sum = {1'b0, credit} + {1'b0, sel_value};

  always_comb begin
    state_n    = state;
    credit_n   = credit;
    coin_err_n = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (sel_valid && stock_ok) begin
          coin_err_n = sel_multi;
          if (sum >= PRICE_W) begin
            state_n  = VEND;
            credit_n = CW'(sum - PRICE_W);
          end else begin
            state_n  = COLLECT;
            credit_n = sum[CW-1:0];
          end
        end else begin
          coin_err_n = sel_valid;
          if (cancel && state == COLLECT) state_n = REFUND;
        end
      end
      VEND: begin
        coin_err_n = sel_valid;
        state_n    = (credit != '0) ? REFUND : IDLE;
      end
      REFUND: begin
        coin_err_n = sel_valid;
        if (change_ack) begin
          state_n  = IDLE;
          credit_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      credit   <= '0;
      coin_err <= 1'b0;
    end else begin
      state    <= state_n;
      credit   <= credit_n;
      coin_err <= coin_err_n;
    end
  end

  assign dispense     = (state == VEND);
  assign change_valid = (state == REFUND);
  assign busy         = (state == VEND) || (state == REFUND);
  assign change       = change_valid ? credit : '0;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Self-checking bench for vend_fsm_param: directed scenarios followed by
// random stimulus, all checked against a transaction-level credit model.
module tb_vend_fsm_param;

  localparam int CW         = 4;
  localparam int PRICE      = 5;
  localparam int VAL_A      = 1;
  localparam int VAL_B      = 2;
  localparam int VAL_C      = 5;
  localparam int STOCK_INIT = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          coin_a, coin_b, coin_c, cancel, change_ack;
  logic          dispense, change_valid, busy, coin_err;
  logic [CW-1:0] change, credit;
`ifdef VEND_STOCK_EN
  logic          restock;
  logic          sold_out;
  int            m_stock;
  bit            keep_stocked;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: credit held, product being handed out, change owed.
  int m_credit;
  bit m_vend;
  bit m_owed;
  bit m_err;

  always #5 clk = ~clk;

  vend_fsm_param #(
    .CW(CW), .PRICE(PRICE), .VAL_A(VAL_A), .VAL_B(VAL_B), .VAL_C(VAL_C)
`ifdef VEND_STOCK_EN
    , .STOCK_W(4), .STOCK_INIT(STOCK_INIT)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .coin_a       (coin_a),
    .coin_b       (coin_b),
    .coin_c       (coin_c),
    .cancel       (cancel),
    .change_ack   (change_ack),
    .dispense     (dispense),
    .change_valid (change_valid),
    .change       (change),
    .credit       (credit),
    .busy         (busy),
    .coin_err     (coin_err)
`ifdef VEND_STOCK_EN
    , .restock    (restock),
    .sold_out     (sold_out)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0;
    m_vend   = 0;
    m_owed   = 0;
    m_err    = 0;
`ifdef VEND_STOCK_EN
    m_stock  = STOCK_INIT;
`endif
  endtask

  task automatic model_step(input bit a, input bit b, input bit c, input bit can,
                            input bit ack, input bit rs);
    int  n;
    int  total;
    bit  have_stock;
    bit  start_vend;
    n          = int'(a) + int'(b) + int'(c);
    have_stock = 1'b1;
    start_vend = 1'b0;
`ifdef VEND_STOCK_EN
    have_stock = (m_stock > 0);
`endif
    m_err = 0;
    if (m_vend) begin
      m_err  = (n > 0);
      m_vend = 0;
      m_owed = (m_credit > 0);
    end else if (m_owed) begin
      m_err = (n > 0);
      if (ack) begin
        m_owed   = 0;
        m_credit = 0;
      end
    end else if (n > 0 && have_stock) begin
      total = m_credit + (a ? VAL_A : (b ? VAL_B : VAL_C));
      m_err = (n > 1);
      if (total >= PRICE) begin
        m_vend     = 1;
        start_vend = 1;
        m_credit   = total - PRICE;
      end else begin
        m_credit = total;
      end
    end else begin
      m_err = (n > 0);
      if (can && m_credit > 0) m_owed = 1;
    end
`ifdef VEND_STOCK_EN
    if (rs)              m_stock = STOCK_INIT;
    else if (start_vend) m_stock = m_stock - 1;
`else
    if (rs && start_vend) m_err = m_err;
`endif
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ":dispense"},     dispense,     m_vend);
    chk({tag, ":change_valid"}, change_valid, m_owed);
    chk({tag, ":change"},       change,       m_owed ? m_credit : 0);
    chk({tag, ":credit"},       credit,       m_credit);
    chk({tag, ":busy"},         busy,         m_vend | m_owed);
    chk({tag, ":coin_err"},     coin_err,     m_err);
`ifdef VEND_STOCK_EN
    chk({tag, ":sold_out"},     sold_out,     m_stock == 0);
`endif
  endtask

  // Drive inputs on the falling edge, check #1 after the rising edge.
  task automatic step(input string tag, input bit a, input bit b, input bit c,
                      input bit can, input bit ack);
    bit rs;
    rs = 1'b0;
    @(negedge clk);
    coin_a = a; coin_b = b; coin_c = c; cancel = can; change_ack = ack;
`ifdef VEND_STOCK_EN
    restock = keep_stocked;
    rs      = keep_stocked;
`endif
    @(posedge clk);
    model_step(a, b, c, can, ack, rs);
    #1;
    compare_all(tag);
  endtask

  initial begin
    coin_a = 0; coin_b = 0; coin_c = 0; cancel = 0; change_ack = 0;
`ifdef VEND_STOCK_EN
    restock = 0;
    keep_stocked = 1;
`endif
    reset = 1'b1;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // 1: coin_c in IDLE vends immediately with no change
    step("t1_coin", 0, 0, 1, 0, 0);
    chk("t1_dispense", dispense, 1);
    chk("t1_credit", credit, 0);
    step("t1_idle", 0, 0, 0, 0, 0);
    chk("t1_no_change", change_valid, 0);
    chk("t1_dispense_done", dispense, 0);

    // 2: three coin_b -> vend with change 1, change held while ack low
    step("t2_b1", 0, 1, 0, 0, 0);
    chk("t2_credit2", credit, 2);
    step("t2_b2", 0, 1, 0, 0, 0);
    chk("t2_credit4", credit, 4);
    step("t2_b3", 0, 1, 0, 0, 0);
    chk("t2_vend", dispense, 1);
    for (int i = 0; i < 4; i++) step("t2_hold", 0, 0, 0, 0, 0);
    chk("t2_change1", change, 1);
    step("t2_ack", 0, 0, 0, 0, 1);
    chk("t2_cleared", credit, 0);

    // 3: two coin_a then cancel refunds 2 without dispensing
    step("t3_a1", 1, 0, 0, 0, 0);
    step("t3_a2", 1, 0, 0, 0, 0);
    step("t3_cancel", 0, 0, 0, 1, 0);
    chk("t3_change2", change, 2);
    chk("t3_no_vend", dispense, 0);
    step("t3_ack", 0, 0, 0, 0, 1);

    // 4: simultaneous coins, then a coin rejected during REFUND
    step("t4_ab", 1, 1, 0, 0, 0);
    chk("t4_credit1", credit, 1);
    chk("t4_err", coin_err, 1);
    step("t4_quiet", 0, 0, 0, 0, 0);
    chk("t4_err_pulse", coin_err, 0);
    step("t4_cancel", 0, 0, 0, 1, 0);
    step("t4_c_in_refund", 0, 0, 1, 0, 0);
    chk("t4_err_refund", coin_err, 1);
    chk("t4_change_kept", change, 1);
    step("t4_ack", 0, 0, 0, 0, 1);

    // 5: asynchronous reset while refunding change 3
    step("t5_b", 0, 1, 0, 0, 0);
    step("t5_a", 1, 0, 0, 0, 0);
    step("t5_c", 0, 0, 1, 0, 0);
    step("t5_refund", 0, 0, 0, 0, 0);
    chk("t5_change3", change, 3);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all("t5_async_reset");
    @(negedge clk);
    reset = 1'b0;
    step("t5_after", 1, 0, 0, 0, 0);
    chk("t5_credit1", credit, 1);
    step("t5_cancel", 0, 0, 0, 1, 0);
    step("t5_ack", 0, 0, 0, 0, 1);

`ifdef VEND_STOCK_EN
    // 6: single-item stock runs out, rejects coins, then restocks
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    keep_stocked = 0;
    step("t6_c", 0, 0, 1, 0, 0);
    chk("t6_vend", dispense, 1);
    chk("t6_sold_out", sold_out, 1);
    step("t6_a_rejected", 1, 0, 0, 0, 0);
    chk("t6_err", coin_err, 1);
    chk("t6_credit0", credit, 0);
    keep_stocked = 1;
    step("t6_restock", 0, 0, 0, 0, 0);
    chk("t6_restocked", sold_out, 0);
    keep_stocked = 0;
    step("t6_c2", 0, 0, 1, 0, 0);
    chk("t6_vend2", dispense, 1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
`ifdef VEND_STOCK_EN
      keep_stocked = ($urandom_range(0, 7) == 0);
`endif
      step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
